// File: rtl/packet_serializer.sv
// Packet-to-flit serializer: pops one wide packet from a registered-output FIFO
// and streams it out LSB-first as NUM_FLITS flits under valid/ready handshaking.
module packet_serializer #(
  parameter int PACKET_WIDTH = 128,
  parameter int FLIT_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  input  logic [PACKET_WIDTH-1:0] fifo_rd_data,
  output logic                    flit_valid,
  input  logic                    flit_ready,
  output logic [FLIT_WIDTH-1:0]   flit_data,
  output logic                    flit_last,
  output logic                    busy,
  output logic [15:0]             pkt_sent
);

  localparam int NUM_FLITS = PACKET_WIDTH / FLIT_WIDTH;
  localparam int IDX_W     = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FLITS - 1);

  if ((PACKET_WIDTH % FLIT_WIDTH) != 0 || NUM_FLITS < 2) begin : g_bad_params
    $error("packet_serializer: PACKET_WIDTH must be a multiple of FLIT_WIDTH with at least 2 flits");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_e;

  state_e                                   state_q;
  logic [IDX_W-1:0]                         idx_q;
  logic [NUM_FLITS-1:0][FLIT_WIDTH-1:0]     pkt_q;
  logic [15:0]                              pkt_sent_q;
  logic                                     at_last;
  logic                                     xfer_last;

  assign at_last   = (state_q == SEND) && (idx_q == LAST_IDX);
  assign xfer_last = at_last && flit_ready;

  // The pop is combinational so the FIFO's registered data lands exactly in FETCH;
  // the next pop overlaps the final flit transfer to keep one bubble per packet.
  assign fifo_rd_en = !rst && !fifo_empty && ((state_q == IDLE) || xfer_last);

  assign flit_valid = (state_q == SEND);
  assign flit_last  = at_last;
  assign flit_data  = pkt_q[idx_q];
  assign busy       = (state_q != IDLE);
  assign pkt_sent   = pkt_sent_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      pkt_q      <= '0;
      pkt_sent_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) state_q <= FETCH;
        end
        FETCH: begin
          pkt_q   <= fifo_rd_data;
          idx_q   <= '0;
          state_q <= SEND;
        end
        SEND: begin
          if (flit_ready) begin
            if (at_last) begin
              pkt_sent_q <= pkt_sent_q + 16'd1;
              state_q    <= fifo_empty ? IDLE : FETCH;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_serializer.sv
// Directed bench for packet_serializer: small registered-output FIFO model and
// cycle-exact checks of handshake, ordering, backpressure, reset and counter wrap.
module tb_packet_serializer;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [127:0]  fifo_rd_data;
  logic          flit_valid;
  logic          flit_ready;
  logic [31:0]   flit_data;
  logic          flit_last;
  logic          busy;
  logic [15:0]   pkt_sent;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  logic [127:0] fmem [0:7];
  int wr_ptr = 0;
  int rd_ptr = 0;

  localparam logic [127:0] PA = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] PB = 128'h80000001_7FFFFFFF_FFFFFFFF_00000000;
  localparam logic [127:0] PC = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

  packet_serializer #(.PACKET_WIDTH(128), .FLIT_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .flit_valid   (flit_valid),
    .flit_ready   (flit_ready),
    .flit_data    (flit_data),
    .flit_last    (flit_last),
    .busy         (busy),
    .pkt_sent     (pkt_sent)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= fmem[rd_ptr % 8];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [127:0] p);
    fmem[wr_ptr % 8] = p;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  task automatic chk_flit(input string tag, input logic [31:0] d, input logic last, input logic rd);
    #1;
    chk({tag, "_valid"}, 32'(flit_valid), 32'd1);
    chk({tag, "_data"},  flit_data, d);
    chk({tag, "_last"},  32'(flit_last), 32'(last));
    chk({tag, "_rd_en"}, 32'(fifo_rd_en), 32'(rd));
  endtask

  task automatic chk_fetch(input string tag);
    #1;
    chk({tag, "_fetch_valid"}, 32'(flit_valid), 32'd0);
    chk({tag, "_fetch_busy"},  32'(busy), 32'd1);
    chk({tag, "_fetch_rd_en"}, 32'(fifo_rd_en), 32'd0);
  endtask

  task automatic chk_idle(input string tag);
    #1;
    chk({tag, "_idle_busy"},  32'(busy), 32'd0);
    chk({tag, "_idle_valid"}, 32'(flit_valid), 32'd0);
    chk({tag, "_pkt_sent"},   32'(pkt_sent), 32'(exp_cnt));
  endtask

  initial begin
    rst        = 1'b1;
    flit_ready = 1'b1;
    nxt; nxt;
    #1;
    chk("rst_valid", 32'(flit_valid), 32'd0);
    chk("rst_last",  32'(flit_last), 32'd0);
    chk("rst_data",  flit_data, 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_cnt",   32'(pkt_sent), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    nxt; rst = 1'b0;

    // empty FIFO for 20 cycles
    for (int i = 0; i < 20; i++) begin
      nxt; #1;
      chk("empty_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("empty_valid", 32'(flit_valid), 32'd0);
      chk("empty_busy",  32'(busy), 32'd0);
    end

    // single packet, ready held high
    nxt; push(PA); #1;
    chk("single_rd_en_T", 32'(fifo_rd_en), 32'd1);
    nxt; chk_fetch("single");
    nxt; chk_flit("single_f0", 32'h11111111, 1'b0, 1'b0);
    nxt; chk_flit("single_f1", 32'h22222222, 1'b0, 1'b0);
    nxt; chk_flit("single_f2", 32'h33333333, 1'b0, 1'b0);
    nxt; chk_flit("single_f3", 32'h44444444, 1'b1, 1'b0);
    exp_cnt = 1;
    nxt; chk_idle("single");

    // backpressure on the 0x22222222 flit
    nxt; push(PA); #1;
    chk("bp_rd_en_T", 32'(fifo_rd_en), 32'd1);
    nxt; chk_fetch("bp");
    nxt; chk_flit("bp_f0", 32'h11111111, 1'b0, 1'b0);
    nxt; flit_ready = 1'b0; chk_flit("bp_f1_stall0", 32'h22222222, 1'b0, 1'b0);
    nxt; chk_flit("bp_f1_stall1", 32'h22222222, 1'b0, 1'b0);
    nxt; chk_flit("bp_f1_stall2", 32'h22222222, 1'b0, 1'b0);
    nxt; flit_ready = 1'b1; chk_flit("bp_f1_go", 32'h22222222, 1'b0, 1'b0);
    nxt; chk_flit("bp_f2", 32'h33333333, 1'b0, 1'b0);
    nxt; flit_ready = 1'b0; chk_flit("bp_f3_stall", 32'h44444444, 1'b1, 1'b0);
    nxt; flit_ready = 1'b1; chk_flit("bp_f3_go", 32'h44444444, 1'b1, 1'b0);
    exp_cnt = 2;
    nxt; chk_idle("bp");

    // back-to-back packets
    nxt; push(PB); push(PC); #1;
    chk("b2b_rd_en_T", 32'(fifo_rd_en), 32'd1);
    nxt; chk_fetch("b2b_p1");
    nxt; chk_flit("b2b_p1_f0", 32'h00000000, 1'b0, 1'b0);
    nxt; chk_flit("b2b_p1_f1", 32'hFFFFFFFF, 1'b0, 1'b0);
    nxt; chk_flit("b2b_p1_f2", 32'h7FFFFFFF, 1'b0, 1'b0);
    nxt; chk_flit("b2b_p1_f3_rd_T5", 32'h80000001, 1'b1, 1'b1);
    exp_cnt = 3;
    nxt; chk_fetch("b2b_p2");
    chk("b2b_cnt_mid", 32'(pkt_sent), 32'(exp_cnt));
    nxt; chk_flit("b2b_p2_f0_T7", 32'hAAAAAAAA, 1'b0, 1'b0);
    nxt; chk_flit("b2b_p2_f1", 32'hBBBBBBBB, 1'b0, 1'b0);
    nxt; chk_flit("b2b_p2_f2", 32'hCCCCCCCC, 1'b0, 1'b0);
    nxt; chk_flit("b2b_p2_f3", 32'hDDDDDDDD, 1'b1, 1'b0);
    exp_cnt = 4;
    nxt; chk_idle("b2b");

    // reset in the middle of a packet, with another packet waiting
    nxt; push(PA); #1;
    chk("rstmid_rd_en_T", 32'(fifo_rd_en), 32'd1);
    nxt; chk_fetch("rstmid");
    nxt; chk_flit("rstmid_f0", 32'h11111111, 1'b0, 1'b0);
    nxt; push(PC); rst = 1'b1; #1;
    chk("rstmid_rd_en_in_rst0", 32'(fifo_rd_en), 32'd0);
    nxt; #1;
    chk("rstmid_rd_en_in_rst1", 32'(fifo_rd_en), 32'd0);
    chk("rstmid_valid_in_rst",  32'(flit_valid), 32'd0);
    nxt; rst = 1'b0; exp_cnt = 0; #1;
    chk("rstmid_after_valid", 32'(flit_valid), 32'd0);
    chk("rstmid_after_busy",  32'(busy), 32'd0);
    chk("rstmid_after_cnt",   32'(pkt_sent), 32'd0);
    chk("rstmid_after_rd_en", 32'(fifo_rd_en), 32'd1);
    nxt; chk_fetch("rstmid_next");
    nxt; chk_flit("rstmid_next_f0", 32'hAAAAAAAA, 1'b0, 1'b0);
    nxt; chk_flit("rstmid_next_f1", 32'hBBBBBBBB, 1'b0, 1'b0);
    nxt; chk_flit("rstmid_next_f2", 32'hCCCCCCCC, 1'b0, 1'b0);
    nxt; chk_flit("rstmid_next_f3", 32'hDDDDDDDD, 1'b1, 1'b0);
    exp_cnt = 1;
    nxt; chk_idle("rstmid_next");

    // counter wrap: preload the idle counter to 0xFFFF
    nxt; force dut.pkt_sent_q = 16'hFFFF;
    nxt; release dut.pkt_sent_q;
    nxt; #1;
    chk("wrap_pre", 32'(pkt_sent), 32'h0000FFFF);
    nxt; push(PB); #1;
    chk("wrap_rd_en_T", 32'(fifo_rd_en), 32'd1);
    nxt; chk_fetch("wrap");
    nxt; chk_flit("wrap_f0", 32'h00000000, 1'b0, 1'b0);
    nxt; chk_flit("wrap_f1", 32'hFFFFFFFF, 1'b0, 1'b0);
    nxt; chk_flit("wrap_f2", 32'h7FFFFFFF, 1'b0, 1'b0);
    #1; chk("wrap_before_last", 32'(pkt_sent), 32'h0000FFFF);
    nxt; chk_flit("wrap_f3", 32'h80000001, 1'b1, 1'b0);
    exp_cnt = 0;
    nxt; chk_idle("wrap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
